// File: rtl/simple_uart_tx_pkg.sv
// Shared UART definitions for the transmitter and receiver.
package simple_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_t;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/simple_uart_tx_if.sv
// Byte-push and serial-line signals of the UART transmitter.
// master = bus side that pushes bytes, slave = the transmitter.
interface simple_uart_tx_if;

  logic [7:0]  fifo_in;
  logic        fifo_write;
  logic [7:0]  fifo_level;
  logic        fifo_full;
  logic [15:0] clkdiv;
  logic        baudclk;
  logic        tx;
  logic        tx_busy;

  modport master (
    output fifo_in, fifo_write, clkdiv,
    input  fifo_level, fifo_full, baudclk, tx, tx_busy
  );

  modport slave (
    input  fifo_in, fifo_write, clkdiv,
    output fifo_level, fifo_full, baudclk, tx, tx_busy
  );

endinterface

// File: rtl/medfifo.sv
// Small synchronous FIFO with 2**DEPTH entries, combinational read port
// and occupancy count. Write while full is dropped; pop while empty is ignored.
module medfifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
  input  logic             write,
  output logic [WIDTH-1:0] out_data,
  input  logic             pop,
  output logic             empty,
  output logic             full,
  output logic [7:0]       level
);

  localparam int ENTRIES = 1 << DEPTH;
  localparam int PW      = (DEPTH > 0) ? DEPTH : 1;
  localparam logic [PW-1:0]  PTR_ONE   = 1;
  localparam logic [DEPTH:0] COUNT_ONE = 1;

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [DEPTH:0]   count;
  logic             do_write;
  logic             do_pop;

  // count can only reach 2**DEPTH when every slot is used, so its top bit is "full"
  assign empty    = (count == '0);
  assign full     = count[DEPTH];
  assign level    = 8'(count);
  assign do_write = write && !full;
  assign do_pop   = pop && !empty;
  assign out_data = mem[rd_ptr];

  // Storage array; no reset needed because count gates every read.
  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= in_data;
  end

  // Pointers and occupancy; simultaneous write and pop leave count unchanged.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_write) wr_ptr <= (DEPTH == 0) ? '0 : wr_ptr + PTR_ONE;
      if (do_pop)   rd_ptr <= (DEPTH == 0) ? '0 : rd_ptr + PTR_ONE;
      case ({do_write, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/simple_uart_tx.sv
// 8N1 UART transmitter fed from a byte FIFO.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | driving the start bit (low)
//   DATA  | shifting out sr[0], eight bits LSB first
//   STOP  | driving the stop bit (high); chains straight into START if more data
//
// A bit ends when baud_ctr >= clkdiv, so a clkdiv lowered mid-bit ends the bit
// on the next cycle and clkdiv values of 0 or 1 give one-cycle bits.
module simple_uart_tx
  import simple_uart_tx_pkg::*;
#(
  parameter int DEPTH = 0
) (
  input logic              clk,
  input logic              rst,
  simple_uart_tx_if.slave  bus
);

  uart_state_t state;
  uart_state_t state_next;
  logic [7:0]  sr;
  logic [7:0]  sr_next;
  logic [3:0]  bit_ctr;
  logic [3:0]  bit_ctr_next;
  logic [15:0] baud_ctr;
  logic [15:0] baud_ctr_next;
  logic        tx_q;
  logic        tx_next;
  logic        bit_end;
  logic        fifo_pop;
  logic        fifo_empty;
  logic [7:0]  fifo_data;

  medfifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (1'b0),
    .in_data  (bus.fifo_in),
    .write    (bus.fifo_write),
    .out_data (fifo_data),
    .pop      (fifo_pop),
    .empty    (fifo_empty),
    .full     (bus.fifo_full),
    .level    (bus.fifo_level)
  );

  // State, shift register, counters and the registered serial output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sr       <= '0;
      bit_ctr  <= '0;
      baud_ctr <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_next;
      sr       <= sr_next;
      bit_ctr  <= bit_ctr_next;
      baud_ctr <= baud_ctr_next;
      tx_q     <= tx_next;
    end
  end

  // Next-state, FIFO pop, bit timing and next line level.
  always_comb begin
    state_next    = state;
    sr_next       = sr;
    bit_ctr_next  = bit_ctr;
    baud_ctr_next = baud_ctr;
    fifo_pop      = 1'b0;
    tx_next       = 1'b1;
    bit_end       = (baud_ctr >= bus.clkdiv);

    unique case (state)
      IDLE: begin
        baud_ctr_next = '0;
        if (!fifo_empty) begin
          fifo_pop      = 1'b1;
          sr_next       = fifo_data;
          state_next    = START;
          baud_ctr_next = 16'd1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_ctr_next = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          sr_next      = sr >> 1;
          bit_ctr_next = bit_ctr + 4'd1;
          if (bit_ctr == 4'(UART_DATA_BITS - 1)) state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            sr_next    = fifo_data;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // IDLE handles its own counter load; every other state counts within the bit
    if (state != IDLE) baud_ctr_next = bit_end ? 16'd1 : baud_ctr + 16'd1;

    // Line level is decided from the next state so tx comes straight from a flop
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = sr_next[0];
      default: tx_next = 1'b1;
    endcase
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = (state != IDLE);
  assign bus.baudclk = (state != IDLE) && (baud_ctr == 16'd1);

endmodule
